// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 reaction timer.
//   f1_rt_state_t  - measurement FSM states
//   LIGHTS_ALL_ON  - all lamps lit (default 8-lamp gantry)
//   LIGHTS_OFF     - all lamps dark (lights-out)
package f1_pkg;
  localparam int LIGHTS_W_DFLT = 8;
  localparam logic [LIGHTS_W_DFLT-1:0] LIGHTS_ALL_ON = '1;
  localparam logic [LIGHTS_W_DFLT-1:0] LIGHTS_OFF    = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_FULL   = 3'd2,
    ST_TIMING = 3'd3,
    ST_DONE   = 3'd4,
    ST_FALSE  = 3'd5
  } f1_rt_state_t;
endpackage

// File: rtl/f1_reaction_timer_trig_sync.sv
// trig_sync: brings the raw push-button into the clk domain and emits a
// single-cycle pulse on its rising edge.
//   clk       in  system clock
//   rst       in  async active-low reset
//   trigger   in  raw asynchronous button, active-high
//   trig_edge out one-cycle pulse, rising edge of the synchronized button
module trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic trig_edge
);
  logic r_sync1, r_sync2, r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= trigger;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign trig_edge = r_sync2 & ~r_prev;
endmodule

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: measures driver reaction time (ms) from lights-out to
// a trigger press, flags false starts, and holds the result until the next
// light sequence begins.
//   clk         in  system clock
//   rst         in  async active-low reset
//   ms_tick     in  one-cycle pulse per millisecond
//   lights      in  lamp pattern from the start-light sequencer
//   trigger     in  raw push-button, active-high
//   time_ms     out latched reaction time (0 after a false start)
//   valid       out time_ms holds a valid measurement
//   false_start out press seen before lights-out
//   busy        out sequence in progress (ARMED, FULL, TIMING)
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int LIGHTS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ms_tick,
  input  logic [LIGHTS_W-1:0]  lights,
  input  logic                 trigger,
  output logic [CNT_WIDTH-1:0] time_ms,
  output logic                 valid,
  output logic                 false_start,
  output logic                 busy
);
  localparam logic [LIGHTS_W-1:0]  W_ALL_ON = '1;
  localparam logic [LIGHTS_W-1:0]  W_OFF    = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_MAX - 1'b1;

  f1_rt_state_t         r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_time;
  logic                 r_valid;
  logic                 r_false;
  logic                 w_trig_edge;

  trig_sync u_trig_sync (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .trig_edge (w_trig_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_time  <= '0;
      r_valid <= 1'b0;
      r_false <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (lights != W_OFF) r_state <= ST_ARMED;

        // A press anywhere before lights-out is a false start, even when
        // the lamps go dark in the same cycle.
        ST_ARMED, ST_FULL: begin
          if (w_trig_edge) begin
            r_state <= ST_FALSE;
            r_time  <= '0;
            r_false <= 1'b1;
            r_valid <= 1'b0;
          end else if (r_state == ST_ARMED) begin
            if (lights == W_ALL_ON)   r_state <= ST_FULL;
            else if (lights == W_OFF) r_state <= ST_IDLE;
          end else if (lights == W_OFF) begin
            r_state <= ST_TIMING;
            r_cnt   <= '0;
          end
        end

        // A tick coinciding with the press counts toward the result.
        // Reaching all-ones ends the run as a valid timeout, so the
        // counter never wraps.
        ST_TIMING: begin
          if (w_trig_edge) begin
            r_time  <= (ms_tick && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else if (ms_tick) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_time  <= CNT_MAX;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE, ST_FALSE: begin
          if (lights != W_OFF) begin
            r_state <= ST_ARMED;
            r_valid <= 1'b0;
            r_false <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign time_ms     = r_time;
  assign valid       = r_valid;
  assign false_start = r_false;
  assign busy        = (r_state == ST_ARMED) || (r_state == ST_FULL) ||
                       (r_state == ST_TIMING);
endmodule
